comparador_sequencial_param: RTL

COMPARADOR_SEQUENCIAL_PARAM -- requirements
Module: comparador_sequencial_param

---
 rtl/comparador_sequencial_param.sv | 125 ++++++++++++
 1 files changed

// File: rtl/comparador_sequencial_param.sv
// Handshaked unsigned comparator with registered EQ/GT/LT/hit results,
// a run-length FSM that raises stable after HOLD consecutive hits, and a saturating hit counter.
module comparador_sequencial_param #(
  parameter int WIDTH = 3,
  parameter int HOLD  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             EQ,
  output logic             GT,
  output logic             LT,
  output logic             hit,
  output logic             stable,
  output logic [CNT_W-1:0] hit_count,
  input  logic             clr_count
);

  localparam int RUN_W = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCK
  } state_t;

  state_t           state_q;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic             accept;
  logic             eq_d;
  logic             gt_d;
  logic             lt_d;
  logic             hit_d;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    eq_d  = (A == B);
    gt_d  = (A > B);
    lt_d  = (A < B);
    run_d = run_q + RUN_W'(1);
    unique case (mode)
      2'b00:   hit_d = eq_d;
      2'b01:   hit_d = gt_d;
      2'b10:   hit_d = lt_d;
      default: hit_d = !eq_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      run_q     <= '0;
      out_valid <= 1'b0;
      EQ        <= 1'b0;
      GT        <= 1'b0;
      LT        <= 1'b0;
      hit       <= 1'b0;
      stable    <= 1'b0;
      hit_count <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        EQ        <= eq_d;
        GT        <= gt_d;
        LT        <= lt_d;
        hit       <= hit_d;
        // stable mirrors the next state so it lands on the same edge as hit
        if (!hit_d) begin
          state_q <= IDLE;
          run_q   <= '0;
          stable  <= 1'b0;
        end else begin
          unique case (state_q)
            IDLE: begin
              run_q <= RUN_W'(1);
              if (HOLD == 1) begin
                state_q <= LOCK;
                stable  <= 1'b1;
              end else begin
                state_q <= TRACK;
                stable  <= 1'b0;
              end
            end
            TRACK: begin
              run_q <= run_d;
              if (run_d == RUN_W'(HOLD)) begin
                state_q <= LOCK;
                stable  <= 1'b1;
              end else begin
                stable  <= 1'b0;
              end
            end
            LOCK: begin
              stable <= 1'b1;
            end
            default: begin
              state_q <= IDLE;
              run_q   <= '0;
              stable  <= 1'b0;
            end
          endcase
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (clr_count) begin
        hit_count <= '0;
      end else if (accept && hit_d && (hit_count != '1)) begin
        hit_count <= hit_count + CNT_W'(1);
      end
    end
  end

endmodule
